// File: rtl/arbitro_memoria_dados.sv
// Data-memory arbiter: one memory port shared by the core (port A) and the debug/I-O loader (port B).
// Define ARB_FIXED_PRIO_EN to make A win every unlocked tie instead of round-robin.
module arbitro_memoria_dados #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          req_a_i,
    input  logic          req_b_i,
    input  logic          we_a_i,
    input  logic          we_b_i,
    input  logic          lock_a_i,
    input  logic          lock_b_i,
    input  logic [AW-1:0] addr_a_i,
    input  logic [AW-1:0] addr_b_i,
    input  logic [DW-1:0] wdata_a_i,
    input  logic [DW-1:0] wdata_b_i,
    input  logic [1:0]    dtype_a_i,
    input  logic [1:0]    dtype_b_i,
    output logic          gnt_a_o,
    output logic          gnt_b_o,
    output logic          rvalid_a_o,
    output logic          rvalid_b_o,
    output logic [DW-1:0] rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_data_o,
    output logic [1:0]    mem_dtype_o,
    output logic          mem_esc_o,
    output logic          mem_ler_o,
    input  logic [DW-1:0] mem_q_i,
    output logic          busy_o
);

    localparam int unsigned   CW     = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] MaxCnt = CW'(MAX_LOCK);

    typedef enum logic [1:0] {
        StLivre    = 2'd0,
        StTravadoA = 2'd1,
        StTravadoB = 2'd2
    } state_e;

    state_e        state_q;
    logic [CW-1:0] lock_cnt_q;
    logic          busy_q;
    logic          prio_pend_q;
    logic          prio_b_q;
    logic          rvalid_a_q;
    logic          rvalid_b_q;
    logic [DW-1:0] rdata_q;

    logic          gnt_a;
    logic          gnt_b;
    logic          pick_b;
    logic          rr_pick_b;
    logic          cnt_full;

    assign cnt_full = (lock_cnt_q == MaxCnt);

`ifdef ARB_FIXED_PRIO_EN
    assign rr_pick_b = 1'b0;
`else
    logic last_b_q;
    assign rr_pick_b = ~last_b_q;
`endif

    // Grant decision; a port at its lock limit gets nothing for one cycle while it is released.
    always_comb begin
        gnt_a  = 1'b0;
        gnt_b  = 1'b0;
        pick_b = 1'b0;
        case (state_q)
            StLivre: begin
                if (req_a_i && req_b_i) begin
                    pick_b = prio_pend_q ? prio_b_q : rr_pick_b;
                    gnt_a  = ~pick_b;
                    gnt_b  = pick_b;
                end else begin
                    gnt_a = req_a_i;
                    gnt_b = req_b_i;
                end
            end
            StTravadoA: begin
                if (!cnt_full) begin
                    gnt_a = req_a_i;
                    gnt_b = ~req_a_i & req_b_i;
                end
            end
            StTravadoB: begin
                if (!cnt_full) begin
                    gnt_b = req_b_i;
                    gnt_a = ~req_b_i & req_a_i;
                end
            end
            default: ;
        endcase
        if (reset_i) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_data_o  = '0;
        mem_dtype_o = '0;
        mem_esc_o   = 1'b0;
        mem_ler_o   = 1'b0;
        if (gnt_a) begin
            mem_addr_o  = addr_a_i;
            mem_data_o  = wdata_a_i;
            mem_dtype_o = dtype_a_i;
            mem_esc_o   = we_a_i;
            mem_ler_o   = ~we_a_i;
        end else if (gnt_b) begin
            mem_addr_o  = addr_b_i;
            mem_data_o  = wdata_b_i;
            mem_dtype_o = dtype_b_i;
            mem_esc_o   = we_b_i;
            mem_ler_o   = ~we_b_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StLivre;
            lock_cnt_q  <= '0;
            busy_q      <= 1'b0;
            prio_pend_q <= 1'b0;
            prio_b_q    <= 1'b0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
            rdata_q     <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_b_q    <= 1'b1;
`endif
        end else begin
            rvalid_a_q <= gnt_a & ~we_a_i;
            rvalid_b_q <= gnt_b & ~we_b_i;
            if (rvalid_a_q || rvalid_b_q) begin
                rdata_q <= mem_q_i;
            end
`ifndef ARB_FIXED_PRIO_EN
            if (gnt_a || gnt_b) begin
                last_b_q <= gnt_b;
            end
`endif
            if ((gnt_a || gnt_b) && (state_q == StLivre)) begin
                prio_pend_q <= 1'b0;
            end
            case (state_q)
                StLivre: begin
                    if (gnt_a && lock_a_i) begin
                        state_q    <= StTravadoA;
                        lock_cnt_q <= CW'(1);
                        busy_q     <= 1'b1;
                    end else if (gnt_b && lock_b_i) begin
                        state_q    <= StTravadoB;
                        lock_cnt_q <= CW'(1);
                        busy_q     <= 1'b1;
                    end
                end
                StTravadoA: begin
                    if (cnt_full) begin
                        state_q     <= StLivre;
                        lock_cnt_q  <= '0;
                        busy_q      <= 1'b0;
                        prio_pend_q <= 1'b1;
                        prio_b_q    <= 1'b1;
                    end else if (gnt_a && lock_a_i) begin
                        lock_cnt_q <= lock_cnt_q + CW'(1);
                    end else if (gnt_b && lock_b_i) begin
                        state_q    <= StTravadoB;
                        lock_cnt_q <= CW'(1);
                    end else begin
                        state_q    <= StLivre;
                        lock_cnt_q <= '0;
                        busy_q     <= 1'b0;
                    end
                end
                StTravadoB: begin
                    if (cnt_full) begin
                        state_q     <= StLivre;
                        lock_cnt_q  <= '0;
                        busy_q      <= 1'b0;
                        prio_pend_q <= 1'b1;
                        prio_b_q    <= 1'b0;
                    end else if (gnt_b && lock_b_i) begin
                        lock_cnt_q <= lock_cnt_q + CW'(1);
                    end else if (gnt_a && lock_a_i) begin
                        state_q    <= StTravadoA;
                        lock_cnt_q <= CW'(1);
                    end else begin
                        state_q    <= StLivre;
                        lock_cnt_q <= '0;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StLivre;
                    lock_cnt_q <= '0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // A read in flight when reset arrives is dropped, so the outputs are masked during reset.
    assign gnt_a_o    = gnt_a;
    assign gnt_b_o    = gnt_b;
    assign rvalid_a_o = rvalid_a_q & ~reset_i;
    assign rvalid_b_o = rvalid_b_q & ~reset_i;
    assign rdata_o    = reset_i ? '0 : ((rvalid_a_q || rvalid_b_q) ? mem_q_i : rdata_q);
    assign busy_o     = busy_q & ~reset_i;

    a_gnt_exclusive: assert property (@(posedge clk_i) disable iff (reset_i) !(gnt_a && gnt_b));
    a_lock_a_owns: assert property (@(posedge clk_i) disable iff (reset_i)
        (state_q == StTravadoA && req_a_i) |-> !gnt_b);
    a_lock_b_owns: assert property (@(posedge clk_i) disable iff (reset_i)
        (state_q == StTravadoB && req_b_i) |-> !gnt_a);

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Bench for arbitro_memoria_dados: vector table plus hand sequences, read data via scoreboard.
// Expectations follow ARB_FIXED_PRIO_EN when it is defined.
module tb_arbitro_memoria_dados;

`ifdef ARB_FIXED_PRIO_EN
    localparam logic FixedPrio = 1'b1;
`else
    localparam logic FixedPrio = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        req_a_i = 1'b0, req_b_i = 1'b0, we_a_i = 1'b0, we_b_i = 1'b0;
    logic        lock_a_i = 1'b0, lock_b_i = 1'b0;
    logic [7:0]  addr_a_i = '0, addr_b_i = '0;
    logic [31:0] wdata_a_i = '0, wdata_b_i = '0;
    logic [1:0]  dtype_a_i = 2'b10, dtype_b_i = 2'b01;
    logic        gnt_a_o, gnt_b_o, rvalid_a_o, rvalid_b_o, mem_esc_o, mem_ler_o, busy_o;
    logic [31:0] rdata_o, mem_data_o;
    logic [7:0]  mem_addr_o;
    logic [1:0]  mem_dtype_o;
    logic [31:0] mem_q_i = '0;

    int checks = 0;
    int errors = 0;

    arbitro_memoria_dados #(.AW(8), .DW(32), .MAX_LOCK(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .we_a_i(we_a_i), .we_b_i(we_b_i),
        .lock_a_i(lock_a_i), .lock_b_i(lock_b_i), .addr_a_i(addr_a_i), .addr_b_i(addr_b_i),
        .wdata_a_i(wdata_a_i), .wdata_b_i(wdata_b_i), .dtype_a_i(dtype_a_i), .dtype_b_i(dtype_b_i),
        .gnt_a_o(gnt_a_o), .gnt_b_o(gnt_b_o), .rvalid_a_o(rvalid_a_o), .rvalid_b_o(rvalid_b_o),
        .rdata_o(rdata_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_dtype_o(mem_dtype_o), .mem_esc_o(mem_esc_o), .mem_ler_o(mem_ler_o),
        .mem_q_i(mem_q_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] preload(input logic [7:0] a);
        case (a)
            8'h10:   return 32'hDEADBEEF;
            8'h04:   return 32'h1111_0004;
            8'h08:   return 32'h2222_0008;
            8'h0C:   return 32'h3333_000C;
            8'h30:   return 32'hCAFE_0030;
            default: return {24'h0, a};
        endcase
    endfunction

    function automatic logic [31:0] wd_a(input logic [7:0] a);
        return {24'hA0_0000, a};
    endfunction

    function automatic logic [31:0] wd_b(input logic [7:0] a);
        return {24'hB0_0000, a};
    endfunction

    // Behavioural synchronous memory: read data appears the cycle after the read strobe.
    logic [255:0] written = '0;
    logic [31:0]  wmem [256];
    always @(posedge clk_i) begin
        if (mem_esc_o) begin
            wmem[mem_addr_o]    <= mem_data_o;
            written[mem_addr_o] <= 1'b1;
        end
        if (mem_ler_o) mem_q_i <= written[mem_addr_o] ? wmem[mem_addr_o] : preload(mem_addr_o);
    end

    typedef struct {
        logic        port;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];

    logic [31:0] exp_wr [logic [7:0]];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [7:0] a);
        return exp_wr.exists(a) ? exp_wr[a] : preload(a);
    endfunction

    always @(negedge clk_i) begin
        if (rvalid_a_o || rvalid_b_o) begin
            sb_t e;
            chk("sb_single_rvalid", {rvalid_a_o, rvalid_b_o} == 2'b11, 0);
            if (sb.size() == 0) begin
                chk("sb_unexpected_rvalid", {rvalid_a_o, rvalid_b_o}, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_port", rvalid_b_o, e.port);
                chk("sb_rdata", rdata_o, e.data);
            end
        end
    end

    task automatic drive(input logic ra, wa, la, input logic [7:0] aa,
                         input logic rb, wb, lb, input logic [7:0] ab);
        @(posedge clk_i);
        #1;
        req_a_i = ra; we_a_i = wa; lock_a_i = la; addr_a_i = aa; wdata_a_i = wd_a(aa);
        req_b_i = rb; we_b_i = wb; lock_b_i = lb; addr_b_i = ab; wdata_b_i = wd_b(ab);
        @(negedge clk_i);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"}, {gnt_a_o, gnt_b_o}, 0);
        chk({tag, "_rvalid"}, {rvalid_a_o, rvalid_b_o}, 0);
        chk({tag, "_rdata"}, rdata_o, 0);
        chk({tag, "_strobes"}, {mem_esc_o, mem_ler_o}, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_addr"}, mem_addr_o, 0);
    endtask

    typedef struct {
        logic       ra, wa, la;
        logic [7:0] aa;
        logic       rb, wb, lb;
        logic [7:0] ab;
        logic       ega, egb, ebusy, erva, ervb;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input logic ra, wa, la, input logic [7:0] aa,
                                input logic rb, wb, lb, input logic [7:0] ab,
                                input logic ega, egb, ebusy, erva, ervb);
        vec_t v;
        v.ra = ra; v.wa = wa; v.la = la; v.aa = aa;
        v.rb = rb; v.wb = wb; v.lb = lb; v.ab = ab;
        v.ega = ega; v.egb = egb; v.ebusy = ebusy; v.erva = erva; v.ervb = ervb;
        return v;
    endfunction

    initial begin
        // Round-robin on held writes.
        vecs.push_back(mk(1, 1, 0, 8'h40, 1, 1, 0, 8'h44, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h40, 1, 1, 0, 8'h44, FixedPrio, !FixedPrio, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h40, 1, 1, 0, 8'h44, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h40, 1, 1, 0, 8'h44, FixedPrio, !FixedPrio, 0, 0, 0));
        // Locked write then unlocked read by A while B waits.
        vecs.push_back(mk(1, 1, 1, 8'h20, 1, 0, 0, 8'h30, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h20, 1, 0, 0, 8'h30, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h30, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1));
        // A holds the lock up to the limit, then a forced release hands over to B.
        vecs.push_back(mk(1, 1, 1, 8'h50, 1, 1, 0, 8'h54, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'h50, 1, 1, 0, 8'h54, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'h50, 1, 1, 0, 8'h54, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'h50, 1, 1, 0, 8'h54, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'h50, 1, 1, 0, 8'h54, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'h50, 1, 1, 0, 8'h54, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        // lock without req is ignored.
        vecs.push_back(mk(0, 0, 1, 8'h00, 1, 1, 0, 8'h58, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h5C, 0, 1, 0, 0, 0));
        // B lock blocks A, then B drops req and A is granted in the same cycle.
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h60, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h64, 1, 1, 1, 8'h62, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h64, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h68, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0));
        // Back-to-back reads.
        vecs.push_back(mk(1, 0, 0, 8'h04, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h08, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 8'h0C, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0));

        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        chk_reset_vals("reset");

        // First read: grant and strobe in cycle 0, data in cycle 1, then held.
        drive(1, 0, 0, 8'h10, 0, 0, 0, 8'h00);
        chk("rd0_gnt", {gnt_a_o, gnt_b_o}, 2'b10);
        chk("rd0_ler", {mem_ler_o, mem_esc_o}, 2'b10);
        chk("rd0_addr", mem_addr_o, 8'h10);
        sb.push_back('{1'b0, 32'hDEADBEEF});
        drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        chk("rd1_rvalid_a", rvalid_a_o, 1);
        chk("rd1_rdata", rdata_o, 32'hDEADBEEF);
        drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        chk("rd2_rvalid_a", rvalid_a_o, 0);
        chk("rd2_rdata_hold", rdata_o, 32'hDEADBEEF);

        @(posedge clk_i);
        #1 reset_i = 1'b1;
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        chk_reset_vals("reset2");

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic [7:0]  eaddr;
            logic [31:0] edata;
            logic [1:0]  edtype;
            logic        eesc, eler;
            string       tag;
            v = vecs[i];
            drive(v.ra, v.wa, v.la, v.aa, v.rb, v.wb, v.lb, v.ab);
            eaddr = '0; edata = '0; edtype = '0; eesc = 1'b0; eler = 1'b0;
            if (v.ega) begin
                eaddr = v.aa; edata = wd_a(v.aa); edtype = 2'b10; eesc = v.wa; eler = !v.wa;
            end else if (v.egb) begin
                eaddr = v.ab; edata = wd_b(v.ab); edtype = 2'b01; eesc = v.wb; eler = !v.wb;
            end
            tag = $sformatf("v%0d", i);
            chk({tag, "_gnt"}, {gnt_a_o, gnt_b_o}, {v.ega, v.egb});
            chk({tag, "_busy"}, busy_o, v.ebusy);
            chk({tag, "_rvalid"}, {rvalid_a_o, rvalid_b_o}, {v.erva, v.ervb});
            chk({tag, "_strobes"}, {mem_esc_o, mem_ler_o}, {eesc, eler});
            chk({tag, "_addr"}, mem_addr_o, eaddr);
            chk({tag, "_data"}, mem_data_o, edata);
            chk({tag, "_dtype"}, mem_dtype_o, edtype);
            if (eesc) exp_wr[eaddr] = edata;
            if (eler) sb.push_back('{v.egb, exp_read(eaddr)});
        end

        // Reset right after a B read grant drops the read; the next tie goes to A.
        drive(0, 0, 0, 8'h00, 1, 0, 0, 8'h30);
        chk("rst_rd_gnt_b", {gnt_a_o, gnt_b_o, mem_ler_o}, 3'b011);
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        req_b_i = 1'b0;
        @(negedge clk_i);
        chk_reset_vals("rst_drop");
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        req_a_i = 1'b1; we_a_i = 1'b1; addr_a_i = 8'h70; wdata_a_i = wd_a(8'h70);
        req_b_i = 1'b1; we_b_i = 1'b1; addr_b_i = 8'h74; wdata_b_i = wd_b(8'h74);
        @(negedge clk_i);
        chk("rst_tie_gnt", {gnt_a_o, gnt_b_o}, 2'b10);
        chk("rst_tie_rvalid_b", rvalid_b_o, 0);
        drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
